prog_ram: RTL and testbench

Parametrised, loadable program memory for the 16-bit CPU, feeding instructions to the decoder from the PC address. Successor of the fixed-content instruction store: width and depth are parameters, out-of-range fetches are flagged, and a sequential load port writes a program at run time through a small state machine instead of relying on initial contents only.

---
 rtl/prog_ram_if.sv | 32 +++
 rtl/prog_ram.sv | 107 ++++++++++
 tb/tb_prog_ram.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_ram_if.sv
// Fetch and load bus for prog_ram: PC-side fetch port plus the sequential program-load port.
// The slave modport belongs to the memory; the master modport to the CPU/loader side.
interface prog_ram_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 32
) ();
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] addr;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_oob;
   logic              load_start;
   logic              load_valid;
   logic              load_last;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              load_done;
   logic [CW-1:0]     load_count;

   modport slave (
      input  addr, rd_en, load_start, load_valid, load_last, load_data,
      output rd_data, rd_valid, rd_oob, load_ready, load_done, load_count
   );

   modport master (
      output addr, rd_en, load_start, load_valid, load_last, load_data,
      input  rd_data, rd_valid, rd_oob, load_ready, load_done, load_count
   );
endinterface

// File: rtl/prog_ram.sv
// Loadable program memory: registered fetch port with out-of-range flagging, and an
// IDLE/LOAD state machine that writes a program sequentially from the load port.
module prog_ram #(
   parameter int unsigned        DATA_W    = 16,
   parameter int unsigned        ADDR_W    = 16,
   parameter int unsigned        DEPTH     = 32,
   parameter logic [DATA_W-1:0]  FILL_WORD = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   prog_ram_if.slave      bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic {StIdle, StLoad} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     wp_q, wp_d;
   logic [CW-1:0]     count_q, count_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_oob_q, rd_oob_d;

   // Words are stored XOR FILL_WORD so an all-zero power-up array reads back as FILL_WORD.
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic              in_range;
   logic [DATA_W-1:0] rd_word;

   assign in_range = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));
   assign rd_word  = mem_q[bus.addr[AW-1:0]] ^ FILL_WORD;

   always_comb begin
      state_d    = state_q;
      wp_d       = wp_q;
      count_d    = count_q;
      done_d     = 1'b0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_oob_d   = rd_oob_q;
      mem_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.rd_en) begin
               rd_valid_d = 1'b1;
               rd_data_d  = in_range ? rd_word : FILL_WORD;
               rd_oob_d   = ~in_range;
            end
            if (bus.load_start) begin
               state_d = StLoad;
               wp_d    = '0;
               count_d = '0;
            end
         end
         StLoad: begin
            if (bus.load_valid) begin
               mem_we  = 1'b1;
               wp_d    = wp_q + AW'(1);
               count_d = count_q + CW'(1);
               // Leave on the last word or when the final location is written; never wrap.
               if (bus.load_last || (wp_q == AW'(DEPTH - 1))) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wp_q       <= '0;
         count_q    <= '0;
         done_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_oob_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wp_q       <= wp_d;
         count_q    <= count_d;
         done_q     <= done_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_oob_q   <= rd_oob_d;
      end
   end

   // Contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wp_q] <= bus.load_data ^ FILL_WORD;
      end
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_oob     = rd_oob_q;
   assign bus.load_ready = (state_q == StLoad);
   assign bus.load_done  = done_q;
   assign bus.load_count = count_q;
endmodule

// File: tb/tb_prog_ram.sv
// Scoreboard bench for prog_ram: stimulus pushes expected fetch results and load counts,
// a negedge monitor pops and compares whenever the DUT presents rd_valid or load_done.
module tb_prog_ram;
   localparam int unsigned DW    = 16;
   localparam int unsigned AWD   = 16;
   localparam int unsigned DEPTH = 32;
   localparam logic [15:0] FILL  = 16'hF00F;

   typedef struct packed {
      logic [15:0] data;
      logic        oob;
   } rd_exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   prog_ram_if #(.DATA_W(DW), .ADDR_W(AWD), .DEPTH(DEPTH)) bus ();

   prog_ram #(
      .DATA_W   (DW),
      .ADDR_W   (AWD),
      .DEPTH    (DEPTH),
      .FILL_WORD(FILL)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   rd_exp_t     rd_q[$];
   int          done_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_hold = 16'h0000;
   logic        exp_oob_hold = 1'b0;
   logic [15:0] wbuf [64];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: all DUT outputs are sampled on the falling edge.
   always @(negedge clk) begin
      rd_exp_t e;
      if (!rst_n) begin
         check("reset rd_valid", 32'(bus.rd_valid), 0);
         check("reset rd_data", 32'(bus.rd_data), 0);
         check("reset rd_oob", 32'(bus.rd_oob), 0);
         check("reset load_ready", 32'(bus.load_ready), 0);
         check("reset load_done", 32'(bus.load_done), 0);
         check("reset load_count", 32'(bus.load_count), 0);
         exp_hold     = 16'h0000;
         exp_oob_hold = 1'b0;
      end else begin
         if (bus.load_done) begin
            check("load_done with load_ready", 32'(bus.load_ready), 0);
            if (done_q.size() == 0) check("unexpected load_done", 32'(bus.load_done), 0);
            else check("load_count", 32'(bus.load_count), 32'(done_q.pop_front()));
         end
         if (bus.rd_valid) begin
            if (rd_q.size() == 0) begin
               check("unexpected rd_valid", 32'(bus.rd_valid), 0);
            end else begin
               e = rd_q.pop_front();
               check("rd_data", 32'(bus.rd_data), 32'(e.data));
               check("rd_oob", 32'(bus.rd_oob), 32'(e.oob));
               exp_hold     = e.data;
               exp_oob_hold = e.oob;
            end
         end else begin
            check("rd_data hold", 32'(bus.rd_data), 32'(exp_hold));
            check("rd_oob hold", 32'(bus.rd_oob), 32'(exp_oob_hold));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] a, input logic [15:0] d, input logic oob);
      rd_exp_t e;
      e.data = d;
      e.oob  = oob;
      bus.rd_en = 1'b1;
      bus.addr  = a;
      rd_q.push_back(e);
      step();
   endtask

   task automatic idle(input int n);
      bus.rd_en = 1'b0;
      repeat (n) step();
   endtask

   // exp_cnt < 0: no load_done is expected (session cut short by the caller).
   task automatic load(input int n, input bit use_last, input int exp_cnt);
      if (exp_cnt >= 0) done_q.push_back(exp_cnt);
      bus.load_start = 1'b1;
      step();
      bus.load_start = 1'b0;
      check("load_ready after start", 32'(bus.load_ready), 1);
      for (int i = 0; i < n; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = wbuf[i];
         bus.load_last  = use_last && (i == n - 1);
         step();
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      if (exp_cnt >= 0) check("load_ready after exit", 32'(bus.load_ready), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.addr       = '0;
      bus.rd_en      = 1'b0;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      bus.load_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Power-up contents read as FILL_WORD, in range; then hold with rd_en low.
      for (int a = 0; a < 4; a++) fetch(16'(a), FILL, 1'b0);
      idle(2);

      // Reset after 3 of 5 words: written words survive, no load_done.
      wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
      load(3, 1'b0, -1);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      check("load_ready after reset", 32'(bus.load_ready), 0);
      fetch(16'd0, 16'h1111, 1'b0);
      fetch(16'd1, 16'h2222, 1'b0);
      fetch(16'd2, 16'h3333, 1'b0);
      fetch(16'd3, FILL, 1'b0);
      idle(2);

      // Fibonacci program, fetched from the earliest IDLE cycle.
      wbuf[0] = 16'h0801; wbuf[1] = 16'h1100; wbuf[2] = 16'h1604;
      wbuf[3] = 16'h3800; wbuf[4] = 16'h7001;
      load(5, 1'b1, 5);
      fetch(16'd0, 16'h0801, 1'b0);
      fetch(16'd1, 16'h1100, 1'b0);
      fetch(16'd2, 16'h1604, 1'b0);
      fetch(16'd3, 16'h3800, 1'b0);
      fetch(16'd4, 16'h7001, 1'b0);
      idle(1);

      // Out-of-range boundary.
      fetch(16'd32, FILL, 1'b1);
      fetch(16'hFFFF, FILL, 1'b1);
      fetch(16'd31, FILL, 1'b0);
      idle(2);

      // 40 words without load_last: stops at 32, no wrap.
      for (int i = 0; i < 40; i++) wbuf[i] = 16'h0100 + 16'(i);
      load(40, 1'b0, 32);
      fetch(16'd0, 16'h0100, 1'b0);
      fetch(16'd31, 16'h011F, 1'b0);
      fetch(16'd7, 16'h0107, 1'b0);
      idle(2);

      // load_start with rd_en: fetch sees old data; rd_en held through LOAD is ignored.
      wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB;
      begin
         rd_exp_t e;
         e.data = 16'h0100;
         e.oob  = 1'b0;
         bus.rd_en = 1'b1;
         bus.addr  = 16'd0;
         rd_q.push_back(e);
      end
      load(2, 1'b1, 2);
      fetch(16'd0, 16'hAAAA, 1'b0);
      fetch(16'd1, 16'hBBBB, 1'b0);
      idle(3);

      check("pending fetch expectations", 32'(rd_q.size()), 0);
      check("pending load_done expectations", 32'(done_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
